// File: rtl/int_alu_pkg.sv
// Shared definitions for the int_alu stages: op encodings, NZCV bit positions,
// issue-stage FSM states and operand-conditioning helpers.
package int_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ADC = 2'd2,
    OP_SBB = 2'd3
  } op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Subtracting forms feed the adder with the one's complement of b.
  function automatic logic op_inverts_b(op_t op);
    return (op == OP_SUB) || (op == OP_SBB);
  endfunction

  // Carry-in: fixed for ADD/SUB, chained from the architectural carry for ADC/SBB.
  function automatic logic op_carry_in(op_t op, logic carry);
    case (op)
      OP_ADD:  return 1'b0;
      OP_SUB:  return 1'b1;
      default: return carry;
    endcase
  endfunction

endpackage

// File: rtl/int_adder_flags.sv
// NZCV flag generation from the adder's conditioned operands and result.
// Purely combinational; only the operand sign bits are needed for overflow.
module int_adder_flags
  import int_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  a_msb,
  input  logic                  b_msb,
  input  logic [DATA_WIDTH-1:0] sum,
  input  logic                  cout,
  output logic [3:0]            flags
);

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = sum[DATA_WIDTH-1];
    flags[FLAG_Z] = (sum == '0);
    flags[FLAG_C] = cout;
    flags[FLAG_V] = (a_msb == b_msb) && (sum[DATA_WIDTH-1] != a_msb);
  end

endmodule

// File: rtl/int_adder_issue.sv
// Issue/sequencing stage in front of int_adder: one op in flight, NZCV response.
// Optional signed saturation of ADD/SUB results under INT_ADDER_ISSUE_SAT_EN.
//
// state    | meaning
// ST_IDLE  | ready for a request
// ST_ISSUE | add_en pulsed, conditioned operands held on add_*
// ST_CAPT  | adder result valid; capture sum, flags, carry
// ST_RESP  | response held until rsp_ready
module int_adder_issue
  import int_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic                  add_en,
  output logic [DATA_WIDTH-1:0] add_a,
  output logic [DATA_WIDTH-1:0] add_b,
  output logic                  add_cin,
  input  logic [DATA_WIDTH-1:0] add_sum,
  input  logic                  add_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_sum,
  output logic [3:0]            rsp_flags,
  output logic                  carry_flag
);

  localparam int MSB = DATA_WIDTH - 1;

  state_t                  state_q, state_d;
  op_t                     op_in;
  logic                    accept;
  logic [3:0]              flags;
  logic [DATA_WIDTH-1:0]   res_sum;

  assign op_in     = op_t'(req_op);
  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_ready && req_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_CAPT;
      ST_CAPT:  state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  int_adder_flags #(.DATA_WIDTH(DATA_WIDTH)) u_flags (
    .a_msb (add_a[MSB]),
    .b_msb (add_b[MSB]),
    .sum   (add_sum),
    .cout  (add_cout),
    .flags (flags)
  );

`ifdef INT_ADDER_ISSUE_SAT_EN
  op_t op_q;

  // Flags and carry keep the raw result; only the returned sum is clamped.
  always_comb begin
    res_sum = add_sum;
    if (((op_q == OP_ADD) || (op_q == OP_SUB)) && flags[FLAG_V])
      res_sum = add_a[MSB] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      op_q <= OP_ADD;
    else if (accept) op_q <= op_in;
  end
`else
  assign res_sum = add_sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      add_en     <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      add_cin    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_flags  <= '0;
      carry_flag <= 1'b0;
    end else begin
      state_q   <= state_d;
      add_en    <= accept;
      rsp_valid <= (state_d == ST_RESP);
      if (accept) begin
        add_a   <= req_a;
        add_b   <= op_inverts_b(op_in) ? ~req_b : req_b;
        add_cin <= op_carry_in(op_in, carry_flag);
      end
      if (state_q == ST_CAPT) begin
        rsp_sum    <= res_sum;
        rsp_flags  <= flags;
        carry_flag <= add_cout;
      end
    end
  end

endmodule

// File: tb/tb_int_adder_issue.sv
// Self-checking bench for int_adder_issue with a behavioural int_adder model.
// Honours INT_ADDER_ISSUE_SAT_EN in its expectations.
module tb_int_adder_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        add_en;
  logic [31:0] add_a, add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_sum;
  logic [3:0]  rsp_flags;
  logic        carry_flag;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] obs_addb, obs_sum;
  logic [3:0]  obs_flags;
  logic        obs_cin, obs_carry;

  always #5 clk = ~clk;

  int_adder_issue #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .add_en     (add_en),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_sum    (add_sum),
    .add_cout   (add_cout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_flags  (rsp_flags),
    .carry_flag (carry_flag)
  );

  // Registered adder, as the real int_adder: result appears the cycle after en.
  initial begin
    add_sum  = '0;
    add_cout = 1'b0;
  end
  always @(posedge clk)
    if (add_en) {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic c_in, output logic [31:0] sum, output logic [3:0] flags,
                                    output logic c_out, output logic [31:0] bc, output logic cin);
    logic [32:0] full;
    bc    = (op == 2'd1 || op == 2'd3) ? ~b : b;
    cin   = (op == 2'd0) ? 1'b0 : (op == 2'd1) ? 1'b1 : c_in;
    full  = {1'b0, a} + {1'b0, bc} + {32'd0, cin};
    sum   = full[31:0];
    c_out = full[32];
    flags = {sum[31], sum == 32'd0, c_out, (a[31] == bc[31]) && (sum[31] != a[31])};
`ifdef INT_ADDER_ISSUE_SAT_EN
    if (op < 2'd2 && flags[0]) sum = a[31] ? 32'h8000_0000 : 32'h7fff_ffff;
`endif
  endfunction

  // Called at a negedge. Runs one op through the full handshake, holding
  // rsp_ready low for 'hold' cycles in RESP while offering a junk request.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    int waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    check("add_en_issue", add_en, 1);
    check("req_ready_issue", req_ready, 0);
    check("add_a_issue", add_a, a);
    obs_addb = add_b;
    obs_cin  = add_cin;
    @(negedge clk);
    check("add_en_capt", add_en, 0);
    check("rsp_valid_capt", rsp_valid, 0);
    check("add_b_held", add_b, obs_addb);
    @(negedge clk);
    check("rsp_valid_resp", rsp_valid, 1);
    obs_sum   = rsp_sum;
    obs_flags = rsp_flags;
    obs_carry = carry_flag;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_op = 2'd0; req_a = 32'h1234_5678; req_b = 32'h1;
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_sum", rsp_sum, obs_sum);
      check("hold_rsp_flags", rsp_flags, obs_flags);
      check("hold_req_ready", req_ready, 0);
      check("hold_add_en", add_en, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_done", rsp_valid, 0);
    check("req_ready_done", req_ready, 1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, exp_addb;
    logic        exp_cin;
    logic [31:0] exp_sum;
    logic [3:0]  exp_flags;
    logic        exp_carry;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] m_sum, m_bc, ra, rb;
    logic [3:0]  m_flags;
    logic        m_cout, m_cin, m_carry;
    logic [1:0]  rop;

    vecs[0] = '{2'd0, 32'h7fff_ffff, 32'h1, 32'h1, 1'b0,
`ifdef INT_ADDER_ISSUE_SAT_EN
                32'h7fff_ffff,
`else
                32'h8000_0000,
`endif
                4'b1001, 1'b0};
    vecs[1] = '{2'd1, 32'd5, 32'd5, 32'hffff_fffa, 1'b1, 32'd0, 4'b0110, 1'b1};
    vecs[2] = '{2'd0, 32'hffff_ffff, 32'h1, 32'h1, 1'b0, 32'd0, 4'b0110, 1'b1};
    vecs[3] = '{2'd2, 32'd0, 32'd0, 32'd0, 1'b1, 32'd1, 4'b0000, 1'b0};
    vecs[4] = '{2'd3, 32'd0, 32'd0, 32'hffff_ffff, 1'b0, 32'hffff_ffff, 4'b1000, 1'b0};
    vecs[5] = '{2'd1, 32'h8000_0000, 32'h1, 32'hffff_fffe, 1'b1,
`ifdef INT_ADDER_ISSUE_SAT_EN
                32'h8000_0000,
`else
                32'h7fff_ffff,
`endif
                4'b0011, 1'b1};

    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_add_en", add_en, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_flags", rsp_flags, 0);
    check("rst_carry", carry_flag, 0);
    check("rst_add_b", add_b, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, (i == 1) ? 5 : 0);
      check("vec_add_b", obs_addb, vecs[i].exp_addb);
      check("vec_add_cin", obs_cin, vecs[i].exp_cin);
      check("vec_rsp_sum", obs_sum, vecs[i].exp_sum);
      check("vec_rsp_flags", obs_flags, vecs[i].exp_flags);
      check("vec_carry", obs_carry, vecs[i].exp_carry);
    end

    // Reset during ISSUE with carry set: result discarded, carry cleared.
    run_op(2'd0, 32'hffff_ffff, 32'h1, 0);
    check("pre_rst_carry", carry_flag, 1);
    req_valid = 1'b1; req_op = 2'd0; req_a = 32'd1; req_b = 32'd2;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_add_en", add_en, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_add_en", add_en, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_carry", carry_flag, 0);
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_rsp_sum", rsp_sum, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_no_rsp", rsp_valid, 0);
    end
    run_op(2'd2, 32'd0, 32'd0, 0);
    check("post_rst_adc_cin", obs_cin, 0);
    check("post_rst_adc_sum", obs_sum, 0);
    m_carry = obs_carry;

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: ra = 32'h7fff_ffff;
        1: ra = 32'h8000_0000;
        2: ra = 32'hffff_ffff;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: rb = 32'h0000_0001;
        1: rb = 32'h8000_0000;
        2: rb = 32'hffff_ffff;
        default: rb = $urandom;
      endcase
      ref_model(rop, ra, rb, m_carry, m_sum, m_flags, m_cout, m_bc, m_cin);
      run_op(rop, ra, rb, int'($urandom_range(0, 2)));
      check("rnd_add_b", obs_addb, m_bc);
      check("rnd_add_cin", obs_cin, m_cin);
      check("rnd_rsp_sum", obs_sum, m_sum);
      check("rnd_rsp_flags", obs_flags, m_flags);
      check("rnd_carry", obs_carry, m_cout);
      m_carry = m_cout;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d of %0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
